// File: rtl/div_tap_strobe_pkg.sv
// Shared game-timing definitions: strobe FSM state encoding and default counter width.
// Both the strobe block and its edge detector import this package.
package div_tap_strobe_pkg;

    localparam int CNT_W_DEF = 16;

    // Legacy-compatible state encoding; kept as plain constants so older blocks can share them.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

endpackage

// File: rtl/div_tap_strobe_edge_rise_det.sv
// Registered rising-edge detector: samples d every cycle, emits a one-cycle pulse on 0->1
// when enabled. The combinational rise term is exported so the owner can act in the same edge.
module edge_rise_det
    import div_tap_strobe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q,
    output logic q_d,
    output logic rise,
    output logic pulse
);

    assign rise = en & q & ~q_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q     <= 1'b0;
            q_d   <= 1'b0;
            pulse <= 1'b0;
        end else begin
            q     <= d;
            q_d   <= q;
            pulse <= rise;
        end
    end

endmodule

// File: rtl/div_tap_strobe.sv
// Tap strobe generator: picks one bit of the free-running divider, and after a short
// settle period issues a single-cycle strobe per rising edge of that bit, counting them.
module div_tap_strobe
    import div_tap_strobe_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      div_res,
    input  logic             en,
    input  logic [4:0]       tap_sel,
    input  logic             cnt_clr,
    output logic             strobe,
    output logic [CNT_W-1:0] strobe_cnt,
    output logic             cnt_wrap,
    output logic             running
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0] state, state_nx;
    logic       settle_cnt, settle_cnt_nx;
    logic [4:0] tap_sel_q, tap_sel_nx;
    logic       sel_change;
    logic       det_en;
    logic       tap_bit;
    logic       tap_q, tap_d;
    logic       rise;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_nx      = state;
        settle_cnt_nx = settle_cnt;
        tap_sel_nx    = tap_sel_q;
        sel_change    = 1'b0;
        if (!en) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx      = ST_SETTLE;
                    settle_cnt_nx = 1'b0;
                    tap_sel_nx    = tap_sel;
                end
                ST_SETTLE: begin
                    if (settle_cnt) state_nx = ST_RUN;
                    else            settle_cnt_nx = 1'b1;
                end
                ST_RUN: begin
                    // A new tap needs two cycles for tap_q/tap_d to both reflect it.
                    if (tap_sel != tap_sel_q) begin
                        sel_change    = 1'b1;
                        state_nx      = ST_SETTLE;
                        settle_cnt_nx = 1'b0;
                        tap_sel_nx    = tap_sel;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            settle_cnt <= 1'b0;
            tap_sel_q  <= 5'd0;
            running    <= 1'b0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_cnt_nx;
            tap_sel_q  <= tap_sel_nx;
            running    <= (state_nx == ST_RUN);
        end
    end

    assign tap_bit = div_res[tap_sel_q];
    assign det_en  = en && (state == ST_RUN) && !sel_change;

    edge_rise_det u_det (
        .clk   (clk),
        .rst   (rst),
        .en    (det_en),
        .d     (tap_bit),
        .q     (tap_q),
        .q_d   (tap_d),
        .rise  (rise),
        .pulse (strobe)
    );

    // Clear has priority over a coincident strobe: count zeroes and no wrap is flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            strobe_cnt <= '0;
            cnt_wrap   <= 1'b0;
        end else if (cnt_clr) begin
            strobe_cnt <= '0;
            cnt_wrap   <= 1'b0;
        end else begin
            if (rise) strobe_cnt <= strobe_cnt + CNT_ONE;
            cnt_wrap <= rise && (&strobe_cnt);
        end
    end

endmodule

// File: tb/tb_div_tap_strobe.sv
// Directed bench for div_tap_strobe: a 16-bit and a 4-bit counter instance share stimulus;
// outputs are sampled on the falling clock edge.
module tb_div_tap_strobe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] div_res;
    logic        en;
    logic [4:0]  tap_sel;
    logic        cnt_clr;

    logic        strobe, cnt_wrap, running;
    logic [15:0] strobe_cnt;
    logic        strobe4, wrap4, running4;
    logic [3:0]  cnt4;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    div_tap_strobe dut (
        .clk(clk), .rst(rst), .div_res(div_res), .en(en), .tap_sel(tap_sel),
        .cnt_clr(cnt_clr), .strobe(strobe), .strobe_cnt(strobe_cnt),
        .cnt_wrap(cnt_wrap), .running(running)
    );

    div_tap_strobe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .div_res(div_res), .en(en), .tap_sel(tap_sel),
        .cnt_clr(cnt_clr), .strobe(strobe4), .strobe_cnt(cnt4),
        .cnt_wrap(wrap4), .running(running4)
    );

    // Free-running divider model, advanced just after each rising edge.
    initial begin
        div_res = 32'd0;
        forever begin
            @(posedge clk);
            #1 div_res = div_res + 32'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_strobe(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!strobe && n < budget);
        check(tag, {31'd0, strobe}, 32'd1);
    endtask

    task automatic period(input string tag, input int exp);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!strobe && n < 100);
        check(tag, n, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b1; tap_sel = 5'd0; cnt_clr = 1'b0;
        repeat (3) step();
        check("rst_strobe", {31'd0, strobe}, 32'd0);
        check("rst_cnt", {16'd0, strobe_cnt}, 32'd0);
        check("rst_wrap", {31'd0, cnt_wrap}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_cnt4", {28'd0, cnt4}, 32'd0);

        // Maximum rate with tap 0, through the 4-bit wrap and clear-on-strobe.
        rst = 1'b1;
        step(); check("settle1_run", {31'd0, running}, 32'd0);
                check("settle1_stb", {31'd0, strobe}, 32'd0);
        step(); check("settle2_run", {31'd0, running}, 32'd0);
                check("settle2_stb", {31'd0, strobe}, 32'd0);
        step(); check("run_entry", {31'd0, running}, 32'd1);
                check("run_entry_stb", {31'd0, strobe}, 32'd0);
        wait_strobe("first_strobe", 2);
        check("first_cnt", {16'd0, strobe_cnt}, 32'd1);
        for (int i = 2; i <= 10; i++) begin
            step(); check("tap0_gap", {31'd0, strobe}, 32'd0);
            step(); check("tap0_pulse", {31'd0, strobe}, 32'd1);
        end
        check("cnt_after10", {16'd0, strobe_cnt}, 32'd10);
        check("cnt4_after10", {28'd0, cnt4}, 32'd10);
        for (int i = 0; i < 5; i++) begin
            step(); step();
        end
        check("cnt4_at15", {28'd0, cnt4}, 32'd15);
        step();
        step();
        check("wrap_strobe", {31'd0, strobe4}, 32'd1);
        check("wrap_cnt4", {28'd0, cnt4}, 32'd0);
        check("wrap_flag4", {31'd0, wrap4}, 32'd1);
        check("cnt16_at16", {16'd0, strobe_cnt}, 32'd16);
        check("wrap_flag16", {31'd0, cnt_wrap}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            step(); check("wrap_drop", {31'd0, wrap4}, 32'd0);
                    check("post_wrap_gap", {31'd0, strobe}, 32'd0);
            step(); check("post_wrap_pulse", {31'd0, strobe}, 32'd1);
        end
        check("cnt4_again15", {28'd0, cnt4}, 32'd15);
        step();
        cnt_clr = 1'b1;
        step();
        check("clr_strobe", {31'd0, strobe}, 32'd1);
        check("clr_cnt4", {28'd0, cnt4}, 32'd0);
        check("clr_wrap4", {31'd0, wrap4}, 32'd0);
        check("clr_cnt16", {16'd0, strobe_cnt}, 32'd0);
        cnt_clr = 1'b0;

        // Tap 3: period 16.
        tap_sel = 5'd3;
        step(); check("tap3_settle", {31'd0, running}, 32'd0);
        wait_strobe("tap3_first", 40);
        check("tap3_running", {31'd0, running}, 32'd1);
        period("tap3_period_a", 16);
        period("tap3_period_b", 16);

        // Reselect 3 -> 1 mid-RUN: two quiet SETTLE cycles, then period 4.
        tap_sel = 5'd1;
        step(); check("resel1_run", {31'd0, running}, 32'd0);
                check("resel1_stb", {31'd0, strobe}, 32'd0);
        step(); check("resel2_run", {31'd0, running}, 32'd0);
                check("resel2_stb", {31'd0, strobe}, 32'd0);
        step(); check("resel_run", {31'd0, running}, 32'd1);
                check("resel_run_stb", {31'd0, strobe}, 32'd0);
        wait_strobe("tap1_first", 10);
        period("tap1_period_a", 4);
        period("tap1_period_b", 4);

        // Clear in RUN, one more strobe, then drop en just before the next strobe edge.
        cnt_clr = 1'b1;
        step(); check("clr_run_cnt", {16'd0, strobe_cnt}, 32'd0);
        cnt_clr = 1'b0;
        wait_strobe("en_pre_strobe", 8);
        check("en_pre_cnt", {16'd0, strobe_cnt}, 32'd1);
        step(); step(); step();
        en = 1'b0;
        step();
        check("en0_running", {31'd0, running}, 32'd0);
        check("en0_strobe", {31'd0, strobe}, 32'd0);
        check("en0_cnt", {16'd0, strobe_cnt}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_strobe", {31'd0, strobe}, 32'd0);
            check("idle_cnt", {16'd0, strobe_cnt}, 32'd1);
        end

        // Asynchronous reset mid-RUN, asserted between clock edges.
        en = 1'b1; tap_sel = 5'd0;
        step(); step();
        step(); check("rerun", {31'd0, running}, 32'd1);
        wait_strobe("pre_reset_strobe", 3);
        #2 rst = 1'b0;
        #1;
        check("async_strobe", {31'd0, strobe}, 32'd0);
        check("async_cnt", {16'd0, strobe_cnt}, 32'd0);
        check("async_running", {31'd0, running}, 32'd0);
        check("async_cnt4", {28'd0, cnt4}, 32'd0);
        step(); step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_strobe", {31'd0, strobe}, 32'd0);
            if (i < 2) check("post_rst_running", {31'd0, running}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
